fpga_config_loader: RTL
=======================

// Module: fpga_config_loader
// PURPOSE
//  Serial configuration loader sitting directly upstream of the virtual FPGA grid.
//  Receives a bit-serial bitstream and assembles one 32-bit config word per logic element.
//  Holds a shadow copy while loading and an active copy driving the grid's lut, lutIns and output-conf inputs.
//  Shadow→active transfer is atomic, so the fabric never sees a partial configuration.
// PARAMETERS
//  R        5   grid rows
//  C        5   grid columns
//  WORD_W   32  config bits per LE (fixed layout below; not meant to be overridden)
// PORTS
//  clk          in   1            single clock, rising edge
//  rst_n        in   1            asynchronous, active-low reset
//  start        in   1            pulse: begin new frame
//  bitIn        in   1            serial config bit
//  bitValid     in   1            bitIn valid this cycle
//  busy         out  1            frame in progress
//  done         out  1            one-cycle pulse: active config updated
//  err          out  1            sticky; cleared by next start
//  lutConf      out  R*C*16       LE k at [k*16 +: 16]
//  lutInsConf   out  R*C*8        LE k at [k*8 +: 8]
//  outConf      out  R*C*8        LE k at [k*8 +: 8], N,E,W,S = [7:6],[5:4],[3:2],[1:0]
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, err=0; shadow, active and all conf outputs = 0.
//    Reset mid-frame discards the frame.
//  - Word layout, MSB first on the wire:
//    - [31:16] lut
//    - [15:8] lutIns, N,E,W,S = [15:14]..[9:8]
//    - [7:0] outConf
//  - LE order: row-major, k = i*C + j; LE 0 is sent first.
//  - FSM IDLE→LOAD on start; busy=1 from the cycle after start.
//  - LOAD: each bitValid cycle shifts bitIn into the word register and increments bitCnt (0..31).
//    - On the 32nd bit, the word is written to shadow[leCnt] and leCnt is incremented.
//    - Cycles without bitValid hold all state; there is no timeout.
//  - After word R*C-1: →CHECK if CONFIG_CRC_EN, else →COMMIT.
//  - COMMIT (one cycle): active <= shadow; done=1 in the following cycle; →IDLE; busy=0 with done.
//  - Latency: done asserts 2 cycles after the final valid config bit, when CRC is disabled.
//  - start while busy: the frame is aborted and restarted at LE 0, bit 0.
//    - Active config is untouched.
//    - err is cleared.
//  - start in the same cycle as a bitValid: start wins and that bit is dropped.
//  - bitValid in IDLE is ignored.
//  - Conf outputs are registered from active only; they change exactly in the done cycle.
// CONFIGURATION
//  CONFIG_CRC_EN defined:
//    - CHECK state receives 8 more valid bits: the CRC-8 (poly 0x07, init 0x00) of all config bits, MSB first.
//    - Match → COMMIT.
//    - Mismatch → IDLE with err=1, no done, active unchanged.
//  CONFIG_CRC_EN undefined:
//    - No CHECK state and no CRC logic; err is tied 0.
// STRUCTURE
//  - Shared package fpga_cfg_pkg:
//    - localparam LE_CFG_W=32, LUT_W=16, LUTINS_W=8, OUTCONF_W=8
//    - field offsets
//    - typedef enum {IDLE, LOAD, CHECK, COMMIT} cfg_state_t
//    - CRC_POLY=8'h07
//  - One sub-module fpga_cfg_crc8: bit-serial CRC-8 with clear, enable and bit inputs.
//    Instantiated only under CONFIG_CRC_EN.
// TESTING
//  1. Reset with rst_n=0 mid-LOAD (LE 3) → busy=0, all conf outputs 0; a following full frame loads cleanly.
//  2. Full frame: every LE word 32'hA5A5_1B2C → lutConf[k*16+:16]=16'hA5A5, lutInsConf=8'h1B, outConf=8'h2C for all k.
//     done pulses once, exactly 2 cycles after the last bit.
//  3. Gaps: bitValid at 25% duty over 800 bits → result identical to scenario 2 and no early done.
//  4. Abort: start after 400 bits, then a full frame of 32'h0000_FFFF.
//     Outputs stay at the prior config until done, then become lut=0, lutIns=8'hFF, outConf=8'hFF.
//  5. CONFIG_CRC_EN: correct CRC → done and commit.
//     One flipped CRC bit → err=1, no done, outputs unchanged; next start clears err.
//  6. Row-major check: LE k word = {16'(k), 8'(k), 8'(~k)} → lutConf for LE 7 (row 1, col 2) = 16'h0007, outConf = 8'hF8.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared widths, field offsets, FSM states and CRC polynomial for the config loader
package fpga_cfg_pkg;
  localparam int LE_CFG_W = 32;
  localparam int LUT_W = 16;
  localparam int LUTINS_W = 8;
  localparam int OUTCONF_W = 8;
  localparam int LUT_OFS = 16;
  localparam int LUTINS_OFS = 8;
  localparam int OUTCONF_OFS = 0;
  localparam logic [7:0] CRC_POLY = 8'h07;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} cfg_state_t;
endpackage

// File: rtl/fpga_config_loader_if.sv
// fpga_config_loader_if: serial bitstream input and per-LE configuration outputs of the loader
interface fpga_config_loader_if #(parameter int R = 5, parameter int C = 5);
  logic start;
  logic bitIn;
  logic bitValid;
  logic busy;
  logic done;
  logic err;
  logic [R*C*16-1:0] lutConf;
  logic [R*C*8-1:0] lutInsConf;
  logic [R*C*8-1:0] outConf;
  modport master(output start, bitIn, bitValid, input busy, done, err, lutConf, lutInsConf, outConf);
  modport slave(input start, bitIn, bitValid, output busy, done, err, lutConf, lutInsConf, outConf);
endinterface

// File: rtl/fpga_cfg_crc8.sv
// fpga_cfg_crc8: bit-serial CRC-8, MSB first, zero init, with synchronous clear
module fpga_cfg_crc8
  import fpga_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);
  logic [7:0] crc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc_q <= '0;
    else if (clr_i) crc_q <= '0;
    else if (en_i) crc_q <= {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bit_i) ? CRC_POLY : 8'h00);
  assign crc_o = crc_q;
endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: assembles serial config words into a shadow store and commits them atomically.
// Define CONFIG_CRC_EN to require a trailing CRC-8 over the frame before commit.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int R = 5,
  parameter int C = 5,
  parameter int WORD_W = LE_CFG_W
) (
  input  logic clk,
  input  logic rst_n,
  fpga_config_loader_if.slave bus
);
  localparam int N = R * C;
  localparam int LW = $clog2(N + 1);
  localparam int BW = $clog2(WORD_W);
  cfg_state_t state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [LW-1:0] le_cnt_q, le_cnt_d;
  logic [N-1:0][WORD_W-1:0] shadow_q, active_q;
  logic done_q, err_q, err_d, shadow_we, crc_ok, commit;
`ifdef CONFIG_CRC_EN
  localparam cfg_state_t LOAD_NEXT = CHECK;
  logic [7:0] crc;
  fpga_cfg_crc8 u_crc (
    .clk(clk), .rst_n(rst_n), .clr_i(bus.start),
    .en_i(state_q == LOAD && bus.bitValid), .bit_i(bus.bitIn), .crc_o(crc)
  );
  assign crc_ok = {word_q[6:0], bus.bitIn} == crc;
`else
  localparam cfg_state_t LOAD_NEXT = COMMIT;
  assign crc_ok = 1'b1;
`endif
  // start overrides everything, including a pending commit
  assign commit = state_q == COMMIT && !bus.start;
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    bit_cnt_d = bit_cnt_q;
    le_cnt_d = le_cnt_q;
    err_d = err_q;
    shadow_we = 1'b0;
    if (bus.start) begin
      state_d = LOAD;
      bit_cnt_d = '0;
      le_cnt_d = '0;
      err_d = 1'b0;
    end else case (state_q)
      LOAD: if (bus.bitValid) begin
        word_d = {word_q[WORD_W-2:0], bus.bitIn};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BW'(WORD_W - 1)) begin
          shadow_we = 1'b1;
          le_cnt_d = le_cnt_q + 1'b1;
          state_d = le_cnt_q == LW'(N - 1) ? LOAD_NEXT : LOAD;
        end
      end
      CHECK: if (bus.bitValid) begin
        word_d = {word_q[WORD_W-2:0], bus.bitIn};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BW'(7)) begin
          state_d = crc_ok ? COMMIT : IDLE;
          err_d = ~crc_ok;
        end
      end
      COMMIT: state_d = IDLE;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      word_q <= '0;
      bit_cnt_q <= '0;
      le_cnt_q <= '0;
      shadow_q <= '0;
      active_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      bit_cnt_q <= bit_cnt_d;
      le_cnt_q <= le_cnt_d;
      err_q <= err_d;
      done_q <= commit;
      if (shadow_we) shadow_q[le_cnt_q] <= word_d;
      if (commit) active_q <= shadow_q;
    end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.err = err_q;
  for (genvar k = 0; k < N; k++) begin : g_le
    assign bus.lutConf[k*LUT_W +: LUT_W] = active_q[k][LUT_OFS +: LUT_W];
    assign bus.lutInsConf[k*LUTINS_W +: LUTINS_W] = active_q[k][LUTINS_OFS +: LUTINS_W];
    assign bus.outConf[k*OUTCONF_W +: OUTCONF_W] = active_q[k][OUTCONF_OFS +: OUTCONF_W];
  end
endmodule
